// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU input sequencer: FSM state encoding,
// opcode width and bit positions of the {N,Z,C,V} flag vector.
package alu_pkg;

  localparam int OP_W   = 4;
  localparam int NZCV_W = 4;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    LOAD_OP = 3'd2,
    EXEC    = 3'd3,
    SHOW    = 3'd4
  } state_t;

endpackage

// File: rtl/alu_input_sequencer_if.sv
// Operand/result bundle between the sequencer (master) and the combinational
// ALU (slave).
interface alu_input_sequencer_if #(
  parameter int WIDTH = 4
);
  import alu_pkg::*;

  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic [OP_W-1:0]   op;
  logic              alu_valid;
  logic [WIDTH-1:0]  alu_result;
  logic [NZCV_W-1:0] alu_nzcv;

  modport master (
    output a, b, op, alu_valid,
    input  alu_result, alu_nzcv
  );

  modport slave (
    input  a, b, op, alu_valid,
    output alu_result, alu_nzcv
  );

endinterface

// File: rtl/btn_edge_sync.sv
// Two-flop synchronizer plus registered rising-edge detector for one raw button.
// Emits a single-cycle event on the third clock edge after the first high sample.
module btn_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic evt
);

  logic s1, s2, prev;
  logic live1, live2;
  logic armed;

  // A button already held when reset releases must not count as a press:
  // armed only sets once s2 carries a genuine post-reset low sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      prev  <= 1'b0;
      live1 <= 1'b0;
      live2 <= 1'b0;
      armed <= 1'b0;
      evt   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let each flop take its neighbour's old value, forming a real shift chain.
      s1    <= btn;
      s2    <= s1;
      prev  <= s2;
      live1 <= 1'b1;
      live2 <= live1;
      if (live2 && !s2) armed <= 1'b1;
      evt   <= s2 & ~prev & armed;
    end
  end

endmodule

// File: rtl/alu_input_sequencer.sv
// Steps the operator through loading A, B and the opcode from switches, fires
// one ALU cycle, then shows the captured result and flags until the next press.
module alu_input_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WIDTH-1:0]        sw,
  input  logic                    btn_next,
  input  logic                    btn_clear,
  alu_input_sequencer_if.master   alu,
  output logic [WIDTH-1:0]        res_q,
  output logic [NZCV_W-1:0]       flags_q,
  output logic [2:0]              state_o
);

  state_t state;
  logic   next_evt;
  logic   clear_evt;

  btn_edge_sync u_next_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_next),
    .evt   (next_evt)
  );

  btn_edge_sync u_clear_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_clear),
    .evt   (clear_evt)
  );

  // alu_valid is registered as "entering EXEC", so it is high for exactly that cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= LOAD_A;
      alu.a         <= '0;
      alu.b         <= '0;
      alu.op        <= '0;
      alu.alu_valid <= 1'b0;
      res_q         <= '0;
      flags_q       <= '0;
    end else if (clear_evt) begin
      state         <= LOAD_A;
      alu.a         <= '0;
      alu.b         <= '0;
      alu.op        <= '0;
      alu.alu_valid <= 1'b0;
      res_q         <= '0;
      flags_q       <= '0;
    end else begin
      case (state)
        LOAD_A: begin
          if (next_evt) begin
            alu.a <= sw;
            state <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (next_evt) begin
            alu.b <= sw;
            state <= LOAD_OP;
          end
        end
        LOAD_OP: begin
          if (next_evt) begin
            alu.op        <= sw[OP_W-1:0];
            alu.alu_valid <= 1'b1;
            state         <= EXEC;
          end
        end
        EXEC: begin
          res_q         <= alu.alu_result;
          flags_q       <= alu.alu_nzcv;
          alu.alu_valid <= 1'b0;
          state         <= SHOW;
        end
        SHOW: begin
          if (next_evt) state <= LOAD_A;
        end
        default: begin
          alu.alu_valid <= 1'b0;
          state         <= LOAD_A;
        end
      endcase
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_alu_input_sequencer.sv
// Randomized self-checking bench: a transaction-level model of the operator
// sequence predicts every register and the state after each button press.
module tb_alu_input_sequencer;
  import alu_pkg::*;

  localparam int W      = 8;
  localparam int SNAP_W = 3 + 3 * W + 4 + 4 + 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] sw;
  logic         btn_next;
  logic         btn_clear;
  logic [W-1:0] res_q;
  logic [3:0]   flags_q;
  logic [2:0]   state_o;

  alu_input_sequencer_if #(.WIDTH(W)) bus ();

  alu_input_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw        (sw),
    .btn_next  (btn_next),
    .btn_clear (btn_clear),
    .alu       (bus),
    .res_q     (res_q),
    .flags_q   (flags_q),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: what the operator should see after each event.
  int         m_state;
  logic [W-1:0] m_a, m_b, m_res;
  logic [3:0] m_op, m_flags;
  logic       m_valid;

  function automatic logic [SNAP_W-1:0] obs_snap();
    return {state_o, bus.a, bus.b, bus.op, res_q, flags_q, bus.alu_valid};
  endfunction

  function automatic logic [SNAP_W-1:0] exp_snap();
    logic [2:0] s;
    s = 3'(m_state);
    return {s, m_a, m_b, m_op, m_res, m_flags, m_valid};
  endfunction

  task automatic model_zero();
    m_state = 0;
    m_a = '0; m_b = '0; m_op = '0; m_res = '0; m_flags = '0; m_valid = 1'b0;
  endtask

  task automatic model_event(input bit nx, input bit cl, input logic [W-1:0] v);
    if (cl) model_zero();
    else if (nx) begin
      case (m_state)
        0: begin m_a = v; m_state = 1; end
        1: begin m_b = v; m_state = 2; end
        2: begin m_op = v[3:0]; m_state = 3; m_valid = 1'b1; end
        4: m_state = 0;
        default: ;
      endcase
    end
  endtask

  // Press one or both buttons for 'hold' sampled cycles and check every cycle.
  task automatic press(input bit nx, input bit cl, input int hold,
                       input logic [W-1:0] v, input logic [W-1:0] r,
                       input logic [3:0] f, input string tag);
    int total;
    bit captured;
    total = ((hold > 5) ? hold : 5) + 3;
    captured = 1'b0;
    @(negedge clk);
    sw = v;
    bus.alu_result = ~r;
    bus.alu_nzcv   = ~f;
    btn_next  = nx;
    btn_clear = cl;
    for (int k = 0; k < total; k++) begin
      @(posedge clk); #1;
      if (k == 3) model_event(nx, cl, v);
      if (k == 4 && m_state == 3) begin
        m_res = r; m_flags = f; m_valid = 1'b0; m_state = 4;
        captured = 1'b1;
      end
      checks++;
      if (obs_snap() !== exp_snap()) begin
        errors++;
        $display("FAIL %s edge %0d: got %h want %h", tag, k, obs_snap(), exp_snap());
      end
      if (k == 3) begin
        sw = W'($urandom);
        if (m_state == 3) begin bus.alu_result = r; bus.alu_nzcv = f; end
      end
      if (captured && k == 4) begin bus.alu_result = ~r; bus.alu_nzcv = ~f; end
      @(negedge clk);
      if (k == hold - 1) begin btn_next = 1'b0; btn_clear = 1'b0; end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; btn_next = 1'b0; btn_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_zero();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; btn_next = 1'b0; btn_clear = 1'b0;
    sw = W'($urandom);
    bus.alu_result = W'($urandom);
    bus.alu_nzcv   = 4'($urandom);
    repeat (3) @(posedge clk);
    #1;
    model_zero();
    checks++;
    if (obs_snap() !== exp_snap()) begin
      errors++;
      $display("FAIL reset_state: got %h want %h", obs_snap(), exp_snap());
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (obs_snap() !== exp_snap()) begin
      errors++;
      $display("FAIL reset_idle: got %h want %h", obs_snap(), exp_snap());
    end
  endtask

  task automatic test_basic_sequence();
    logic [W-1:0] r;
    logic [3:0]   f;
    r = W'($urandom);
    f = 4'($urandom);
    press(1'b1, 1'b0, 2, W'(4'b0010), r, f, "basic_a");
    press(1'b1, 1'b0, 3, W'(4'b1011), r, f, "basic_b");
    press(1'b1, 1'b0, 1, W'(4'b0010), r, f, "basic_op_exec");
    press(1'b1, 1'b0, 2, W'($urandom), r, f, "basic_show_to_a");
  endtask

  task automatic test_long_hold();
    press(1'b1, 1'b0, 50, W'($urandom), W'($urandom), 4'($urandom), "long_hold");
  endtask

  task automatic test_clear_in_show();
    press(1'b1, 1'b0, 2, W'($urandom), '0, '0, "cs_a");
    press(1'b1, 1'b0, 2, W'($urandom), '0, '0, "cs_b");
    press(1'b1, 1'b0, 2, W'($urandom), W'(4'b1101), 4'b1000, "cs_exec");
    press(1'b0, 1'b1, 2, W'($urandom), '0, '0, "clear_in_show");
  endtask

  task automatic test_clear_and_next();
    press(1'b1, 1'b0, 2, W'($urandom), '0, '0, "cn_a");
    press(1'b1, 1'b1, 3, W'($urandom), '0, '0, "clear_and_next");
  endtask

  task automatic test_reset_in_exec();
    press(1'b1, 1'b0, 2, W'($urandom), '0, '0, "re_a");
    press(1'b1, 1'b0, 2, W'($urandom), '0, '0, "re_b");
    @(negedge clk);
    sw = W'($urandom);
    btn_next = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    model_event(1'b1, 1'b0, sw);
    checks++;
    if (obs_snap() !== exp_snap()) begin
      errors++;
      $display("FAIL reach_exec: got %h want %h", obs_snap(), exp_snap());
    end
    bus.alu_result = '1;
    bus.alu_nzcv   = 4'b1111;
    rst_n = 1'b0;
    @(posedge clk); #1;
    model_zero();
    checks++;
    if (obs_snap() !== exp_snap()) begin
      errors++;
      $display("FAIL reset_in_exec: got %h want %h", obs_snap(), exp_snap());
    end
    @(negedge clk);
    btn_next = 1'b0;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (obs_snap() !== exp_snap()) begin
      errors++;
      $display("FAIL after_exec_reset: got %h want %h", obs_snap(), exp_snap());
    end
  endtask

  task automatic test_held_through_reset();
    @(negedge clk);
    rst_n = 1'b0;
    btn_next = 1'b1;
    sw = W'($urandom);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_zero();
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if (obs_snap() !== exp_snap()) begin
      errors++;
      $display("FAIL held_through_reset: got %h want %h", obs_snap(), exp_snap());
    end
    @(negedge clk);
    btn_next = 1'b0;
    repeat (4) @(posedge clk);
    press(1'b1, 1'b0, 2, W'($urandom), '0, '0, "repress_after_release");
  endtask

  task automatic test_random();
    for (int t = 0; t < 24; t++) begin
      bit cl;
      cl = ($urandom_range(0, 5) == 0);
      press(~cl, cl, $urandom_range(1, 6), W'($urandom), W'($urandom),
            4'($urandom), "random");
    end
  endtask

  initial begin
    rst_n = 1'b0; sw = '0; btn_next = 1'b0; btn_clear = 1'b0;
    bus.alu_result = '0; bus.alu_nzcv = '0;
    model_zero();
    test_reset();
    test_basic_sequence();
    test_long_hold();
    do_reset();
    test_clear_in_show();
    test_clear_and_next();
    test_reset_in_exec();
    test_held_through_reset();
    do_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_input_sequencer.md
ALU_INPUT_SEQUENCER -- requirements
Module: alu_input_sequencer

Interface
REQ-001 Parameter: WIDTH, default 4, operand/result width; SHALL be >= 4.
REQ-002 clk  input  1  single system clock, all logic on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 sw  input  WIDTH  raw switch value loaded into A, B or opcode.
REQ-005 btn_next  input  1  raw asynchronous "advance" button, active-high.
REQ-006 btn_clear  input  1  raw asynchronous "clear" button, active-high.
REQ-007 alu_result  input  WIDTH  result from the downstream combinational ALU.
REQ-008 alu_nzcv  input  4  ALU flags {N,Z,C,V}.
REQ-009 a  output  WIDTH  registered operand A to the ALU.
REQ-010 b  output  WIDTH  registered operand B to the ALU.
REQ-011 op  output  4  registered operation code to the ALU.
REQ-012 alu_valid  output  1  high for exactly the EXEC cycle.
REQ-013 res_q  output  WIDTH  captured ALU result.
REQ-014 flags_q  output  4  captured {N,Z,C,V}.
REQ-015 state_o  output  3  current state encoding, for LED display.

Function
REQ-016 Each button SHALL pass through a 2-FF synchronizer, then a rising-edge detector producing a 1-cycle event pulse.
REQ-017 A press held high for any duration SHALL produce exactly one event; the event SHALL occur on the 3rd rising clk edge after the button is first sampled high.
REQ-018 FSM states: LOAD_A=0, LOAD_B=1, LOAD_OP=2, EXEC=3, SHOW=4; encodings 5-7 SHALL return to LOAD_A on the next edge.
REQ-019 LOAD_A + next event: a <= sw; go to LOAD_B.
REQ-020 LOAD_B + next event: b <= sw; go to LOAD_OP.
REQ-021 LOAD_OP + next event: op <= sw[3:0]; go to EXEC.
REQ-022 EXEC SHALL last exactly one cycle with alu_valid=1; at the end of that cycle res_q <= alu_result and flags_q <= alu_nzcv; go to SHOW.
REQ-023 SHOW + next event: go to LOAD_A; a, b, op, res_q and flags_q SHALL hold until overwritten.
REQ-024 Without an event, every state except EXEC SHALL hold, and all registers SHALL hold.
REQ-025 A clear event in any state SHALL zero a, b, op, res_q and flags_q and go to LOAD_A on the next edge.
REQ-026 Clear and next events in the same cycle: clear SHALL win and next SHALL be discarded.
REQ-027 A next event during EXEC SHALL be discarded.
REQ-028 op SHALL be forwarded unmodified; opcode decoding and range checks are not done here.
REQ-029 a, b, op and alu_valid SHALL be driven only from flops.

Reset
REQ-030 With rst_n=0 at a clk edge: state=LOAD_A; a, b, op, res_q, flags_q=0; alu_valid=0; all synchronizer and edge flops=0.
REQ-031 Reset mid-EXEC SHALL suppress the capture; res_q and flags_q SHALL be 0.
REQ-032 A button already high when reset releases SHALL NOT generate an event until it is released and pressed again.

Structure
REQ-033 Shared package alu_pkg SHALL hold the state enum type, OP_W=4, and the flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
REQ-034 Sub-module btn_edge_sync (synchronizer plus edge detector) SHALL be instantiated once per button.

Verification
REQ-035 Reset, then press next with sw=0010, then 1011, then op 0010 -> a=0010, b=1011, op=0010; alu_valid pulses for one cycle; then SHOW with res_q/flags_q equal to the ALU outputs sampled in EXEC.
REQ-036 Hold btn_next high for 50 cycles in LOAD_A -> exactly one state advance, on the 3rd edge after the first high sample.
REQ-037 In SHOW with res_q=1101, press btn_clear -> next state LOAD_A; a, b, op, res_q, flags_q=0.
REQ-038 Assert next and clear so that both events fire in the same cycle while in LOAD_B -> state LOAD_A, all registers zero, b not loaded.
REQ-039 Drive rst_n=0 during EXEC with alu_result=1111 -> res_q=0, flags_q=0, state=LOAD_A, alu_valid=0.
REQ-040 Hold btn_next high through reset release -> no event until a low-then-high transition; state stays LOAD_A.
